// File: rtl/zdp_pkg.sv
// Shared mode encoding for the pipelined zero-detect / flag reducer.
package zdp_pkg;

  typedef logic [1:0] zdp_mode_t;

  localparam zdp_mode_t ZDP_ALL_ZERO = 2'd0;
  localparam zdp_mode_t ZDP_ALL_ONES = 2'd1;
  localparam zdp_mode_t ZDP_ANY_ONE  = 2'd2;
  localparam zdp_mode_t ZDP_PARITY   = 2'd3;

endpackage

// File: rtl/zdp_chunk_reduce.sv
// Combinational reduction of one CHUNK-bit leaf under the selected mode.
module zdp_chunk_reduce
  import zdp_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] data,
  input  logic [1:0]       mode,
  output logic             red
);

  always_comb begin
    red = 1'b0;
    case (zdp_mode_t'(mode))
      ZDP_ALL_ZERO: red = ~|data;
      ZDP_ALL_ONES: red = &data;
      ZDP_ANY_ONE:  red = |data;
      ZDP_PARITY:   red = ^data;
      default:      red = 1'b0;
    endcase
  end

endmodule

// File: rtl/zero_detect_pipe.sv
// Two-stage pipelined operand reducer with valid/ready on both sides.
// Define ZDP_FIRST_IDX_EN to add the lowest-set-chunk index outputs.
module zero_detect_pipe
  import zdp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_flag,
  output logic [WIDTH/CHUNK-1:0]   out_chunk,
  output logic [1:0]               out_mode
`ifdef ZDP_FIRST_IDX_EN
  ,
  output logic                     out_first_vld,
  output logic [((WIDTH/CHUNK) > 1 ? $clog2(WIDTH/CHUNK) : 1)-1:0] out_first_idx
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  logic [NCHUNK-1:0] chunk_red;
  logic              s1_valid;
  logic [NCHUNK-1:0] s1_chunk;
  zdp_mode_t         s1_mode;
  logic              s1_load, s2_load;
  logic              flag_nxt;

  for (genvar k = 0; k < NCHUNK; k++) begin : g_leaf
    zdp_chunk_reduce #(.CHUNK(CHUNK)) u_red (
      .data (in_data[k*CHUNK +: CHUNK]),
      .mode (in_mode),
      .red  (chunk_red[k])
    );
  end

  // in_ready looks through both stages so a full pipe still streams at 1/cycle
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign s1_load  = in_valid && in_ready;

  // NOR leaves already invert, so all-zero and all-ones both AND the leaves
  always_comb begin
    flag_nxt = 1'b0;
    case (s1_mode)
      ZDP_ALL_ZERO, ZDP_ALL_ONES: flag_nxt = &s1_chunk;
      ZDP_ANY_ONE:                flag_nxt = |s1_chunk;
      ZDP_PARITY:                 flag_nxt = ^s1_chunk;
      default:                    flag_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_chunk <= '0;
      s1_mode  <= ZDP_ALL_ZERO;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_chunk <= chunk_red;
        s1_mode  <= zdp_mode_t'(in_mode);
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_flag  <= 1'b0;
      out_chunk <= '0;
      out_mode  <= '0;
    end else begin
      if (s2_load) begin
        out_valid <= 1'b1;
        out_flag  <= flag_nxt;
        out_chunk <= s1_chunk;
        out_mode  <= s1_mode;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ZDP_FIRST_IDX_EN
  logic [IDXW-1:0] first_idx_nxt;

  // Scan from the top so the lowest set chunk wins
  always_comb begin
    first_idx_nxt = '0;
    for (int k = NCHUNK - 1; k >= 0; k--)
      if (s1_chunk[k]) first_idx_nxt = IDXW'(k);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_first_vld <= 1'b0;
      out_first_idx <= '0;
    end else if (s2_load) begin
      out_first_vld <= |s1_chunk;
      out_first_idx <= first_idx_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_zero_detect_pipe.sv
// Directed/table-driven bench for zero_detect_pipe (WIDTH=32, CHUNK=8).
module tb_zero_detect_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_flag;
  logic [3:0]  out_chunk;
  logic [1:0]  out_mode;

  always #5 clk = ~clk;

`ifdef ZDP_FIRST_IDX_EN
  logic        out_first_vld;
  logic [1:0]  out_first_idx;
  logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_flag2;
  logic [15:0] in_data2 = '0;
  logic [1:0]  in_mode2 = '0, out_mode2, out_first_idx2;
  logic [3:0]  out_chunk2;
  logic        out_first_vld2;

  zero_detect_pipe #(.WIDTH(16), .CHUNK(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .in_mode(in_mode2), .out_valid(out_valid2),
    .out_ready(1'b1), .out_flag(out_flag2), .out_chunk(out_chunk2),
    .out_mode(out_mode2), .out_first_vld(out_first_vld2),
    .out_first_idx(out_first_idx2)
  );
`endif

  zero_detect_pipe #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_flag(out_flag), .out_chunk(out_chunk),
    .out_mode(out_mode)
`ifdef ZDP_FIRST_IDX_EN
    , .out_first_vld(out_first_vld), .out_first_idx(out_first_idx)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  mode;
    logic        flag;
    logic [3:0]  chunk;
  } vec_t;

  vec_t       vecs [10];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         n_out = 0;
  logic [6:0] exp_q [$];
  int         acc_q [$];

  function automatic logic [4:0] model(input logic [31:0] d, input logic [1:0] m);
    logic [3:0] c;
    logic [7:0] s;
    logic       f;
    c = '0;
    for (int k = 0; k < 4; k++) begin
      s = d[k*8 +: 8];
      case (m)
        2'd0:    c[k] = (s == 8'h00);
        2'd1:    c[k] = (s == 8'hFF);
        2'd2:    c[k] = (s != 8'h00);
        default: c[k] = ^s;
      endcase
    end
    case (m)
      2'd0, 2'd1: f = (c == 4'hF);
      2'd2:       f = (c != 4'h0);
      default:    f = ^c;
    endcase
    return {f, c};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    cyc++;
  endtask

  // Scoreboard step: call right after setting this cycle's inputs
  task automatic observe(input bit lat_chk);
    logic [6:0] e;
    int         c0;
    #1;
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_result: got %0h expected no result", {out_mode, out_flag, out_chunk});
      end else begin
        e  = exp_q.pop_front();
        c0 = acc_q.pop_front();
        chk("result", {out_mode, out_flag, out_chunk}, e);
        if (lat_chk) chk("latency", cyc - c0, 2);
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back({in_mode, model(in_data, in_mode)});
      acc_q.push_back(cyc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bp_d [5];
    logic [6:0]  snap;
    bit          have_snap;
    int          idx, base;

    vecs[0] = '{32'h0000_FF01, 2'd0, 1'b0, 4'b1100};
    vecs[1] = '{32'h0000_FF01, 2'd1, 1'b0, 4'b0010};
    vecs[2] = '{32'h0000_FF01, 2'd2, 1'b1, 4'b0011};
    vecs[3] = '{32'h0000_FF01, 2'd3, 1'b1, 4'b0001};
    vecs[4] = '{32'hFFFF_FFFF, 2'd1, 1'b1, 4'b1111};
    vecs[5] = '{32'hFFFF_FFFF, 2'd0, 1'b0, 4'b0000};
    vecs[6] = '{32'h8000_0000, 2'd2, 1'b1, 4'b1000};
    vecs[7] = '{32'h0101_0101, 2'd3, 1'b0, 4'b1111};
    vecs[8] = '{32'h0000_0007, 2'd3, 1'b1, 4'b0001};
    vecs[9] = '{32'h0000_0000, 2'd2, 1'b0, 4'b0000};
    bp_d = '{32'h0000_0000, 32'h1234_5678, 32'hFF00_00FF, 32'h0000_0100, 32'hFFFF_FFFF};

    // Reset state and first result
    repeat (3) next_cycle();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_flag", out_flag, 0);
    chk("rst_out_chunk", out_chunk, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_in_ready", in_ready, 1);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    in_valid = 1'b1; in_data = 32'h0; in_mode = 2'd0; out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    #1 chk("first_lat1_valid", out_valid, 0);
    next_cycle();
    #1;
    chk("first_valid", out_valid, 1);
    chk("first_flag", out_flag, 1);
    chk("first_chunk", out_chunk, 4'b1111);
    next_cycle();
    #1 chk("first_drained", out_valid, 0);

    // Table vectors, one at a time
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      in_valid = 1'b1; in_data = vecs[i].data; in_mode = vecs[i].mode;
      next_cycle();
      in_valid = 1'b0;
      #1 chk("vec_lat1_valid", out_valid, 0);
      next_cycle();
      #1;
      chk("vec_valid", out_valid, 1);
      chk("vec_flag", out_flag, vecs[i].flag);
      chk("vec_chunk", out_chunk, vecs[i].chunk);
      chk("vec_mode", out_mode, vecs[i].mode);
    end
    next_cycle();

    // Backpressure: only two operands fit, outputs hold while stalled
    out_ready = 1'b0;
    idx = 0;
    have_snap = 1'b0;
    snap = '0;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      in_valid = (idx < 5);
      if (idx < 5) begin in_data = bp_d[idx]; in_mode = 2'(idx); end
      observe(0);
      if (in_valid && in_ready) idx++;
      if (out_valid) begin
        if (!have_snap) begin snap = {out_mode, out_flag, out_chunk}; have_snap = 1'b1; end
        else chk("stall_stable", {out_mode, out_flag, out_chunk}, snap);
      end
    end
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    base = n_out;
    for (int c = 0; c < 20 && (n_out - base) < 5; c++) begin
      next_cycle();
      out_ready = 1'b1;
      in_valid = (idx < 5);
      if (idx < 5) begin in_data = bp_d[idx]; in_mode = 2'(idx); end
      observe(0);
      if (in_valid && in_ready) idx++;
      if ((n_out - base) < 5) chk("bp_drain_valid", out_valid, 1);
    end
    chk("bp_delivered", n_out - base, 5);
    chk("bp_sb_empty", exp_q.size(), 0);
    in_valid = 1'b0;
    next_cycle();

    // Continuous streaming, 1/cycle at fixed latency
    out_ready = 1'b1;
    base = n_out;
    for (int i = 0; i < 100; i++) begin
      next_cycle();
      in_valid = 1'b1; in_data = $urandom; in_mode = 2'($urandom_range(0, 3));
      observe(1);
      chk("stream_in_ready", in_ready, 1);
      if (i >= 2) chk("stream_out_valid", out_valid, 1);
    end
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      in_valid = 1'b0;
      observe(1);
    end
    chk("stream_delivered", n_out - base, 100);
    chk("stream_sb_empty", exp_q.size(), 0);

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    next_cycle();
    in_valid = 1'b1; in_data = 32'h0000_00FF; in_mode = 2'd1;
    next_cycle();
    in_data = 32'h0000_0000; in_mode = 2'd0;
    next_cycle();
    in_valid = 1'b0;
    #1;
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_out_chunk", out_chunk, 0);
    chk("async_in_ready", in_ready, 1);
    next_cycle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      #1 chk("no_stale_valid", out_valid, 0);
    end

`ifdef ZDP_FIRST_IDX_EN
    next_cycle();
    in_valid2 = 1'b1; in_data2 = 16'h0F00; in_mode2 = 2'd2;
    next_cycle();
    in_valid2 = 1'b0;
    next_cycle();
    #1;
    chk("fi_valid", out_valid2, 1);
    chk("fi_vld", out_first_vld2, 1);
    chk("fi_idx", out_first_idx2, 2);
    in_valid2 = 1'b1; in_data2 = 16'h0000; in_mode2 = 2'd2;
    next_cycle();
    in_valid2 = 1'b0;
    next_cycle();
    #1;
    chk("fi_zero_vld", out_first_vld2, 0);
    chk("fi_zero_idx", out_first_idx2, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
